hazard_sequencer: RTL and testbench

- Pipeline controller for the 5-stage MIPS core. Owns the enable and flush strobes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Sequences the pipeline around cache misses, load-use hazards, taken branches/jumps and halt.
- Works alongside forwarding_unit: forwarding resolves EX operand hazards that can be bypassed; this block stalls the ones that cannot (load-use).
- Maintains a saturating stall-cycle counter for performance reporting.

---
 rtl/hazard_sequencer.sv | 119 +++++++++++
 tb/tb_hazard_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline enable/flush sequencing for the 5-stage core.
// Handles dcache-miss freezes, load-use bubbles, branch flushes, icache-miss
// bubbles and halt. It also keeps a saturating count of stall cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal issue; strobes follow the hazard priority
// DWAIT  | MEM access outstanding; pipeline frozen until dhit
// HALTED | HALT reached WB; everything held until reset

module hazard_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_br_taken,
    input  logic             exe_memRd,
    input  logic [4:0]       exe_regDst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    logic memreq;
    logic luse;
    logic miss_freeze;

    assign memreq      = mem_dREN | mem_dWEN;
    assign luse        = exe_memRd & (exe_regDst != 5'd0) &
                         ((exe_regDst == id_rs) | (exe_regDst == id_rt));
    assign miss_freeze = memreq & ~dhit;

    // Strobe decode: first matching hazard wins; reset and HALTED force all off.
    // RUN and DWAIT decode identically, so the dhit cycle advances at once.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!RST && state != HALTED) begin
            if (wb_halt || miss_freeze) begin
                // everything held
            end else if (mem_br_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (luse) begin
                // IF/ID holds even on an icache miss, so its contents survive
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (!ihit) begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // State, halt flag and saturating stall counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (state != HALTED) begin
                if (!pc_en && stall_cnt != {CNT_W{1'b1}})
                    stall_cnt <= stall_cnt + 1'b1;
                if (wb_halt) begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end else if (miss_freeze) begin
                    state <= DWAIT;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed vectors for hazard_sequencer (CNT_W=3).
// Strobes are compared as a packed vector
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}.

module tb_hazard_sequencer;

    localparam int CNT_W = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit, mem_dREN, mem_dWEN, mem_br_taken;
    logic             exe_memRd, wb_halt;
    logic [4:0]       exe_regDst, id_rs, id_rt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, halt;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S_OFF   = 7'b0000000;
    localparam logic [6:0] S_RUN   = 7'b1111100;
    localparam logic [6:0] S_LUSE  = 7'b0011101;
    localparam logic [6:0] S_IMISS = 7'b0111110;
    localparam logic [6:0] S_BR    = 7'b1111111;

    hazard_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_br_taken(mem_br_taken),
        .exe_memRd(exe_memRd), .exe_regDst(exe_regDst),
        .id_rs(id_rs), .id_rt(id_rt), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    wire [6:0] strobes = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                          ifid_flush, idex_flush};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, then settle just after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_br_taken = 1'b0; exe_memRd = 1'b0; wb_halt = 1'b0;
        exe_regDst = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    task automatic reset_pulse();
        RST = 1'b1;
        #1;
        chk("rst_async_cnt", 32'(stall_cnt), 0);
        step();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        #1;

        // reset held for 3 cycles with ihit=1
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_strobes", 32'(strobes), 32'(S_OFF));
            chk("rst_halt", 32'(halt), 0);
            chk("rst_cnt", 32'(stall_cnt), 0);
            step();
        end
        RST = 1'b0;
        #1;
        chk("rel_strobes", 32'(strobes), 32'(S_RUN));
        step();

        // dcache miss: 4 frozen cycles, advance on dhit
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("dmiss_freeze", 32'(strobes), 32'(S_OFF));
            step();
        end
        dhit = 1'b1;
        #1;
        chk("dmiss_hit", 32'(strobes), 32'(S_RUN));
        step();
        chk("dmiss_cnt", 32'(stall_cnt), 4);
        idle_inputs();
        reset_pulse();
        chk("cnt_cleared", 32'(stall_cnt), 0);

        // load-use on rt, then same with regDst=0 (no stall)
        exe_memRd = 1'b1; exe_regDst = 5'd8; id_rt = 5'd8; id_rs = 5'd3;
        #1;
        chk("luse_rt", 32'(strobes), 32'(S_LUSE));
        exe_regDst = 5'd0; id_rt = 5'd0;
        #1;
        chk("luse_r0", 32'(strobes), 32'(S_RUN));
        exe_regDst = 5'd3;
        #1;
        chk("luse_rs", 32'(strobes), 32'(S_LUSE));
        exe_memRd = 1'b0;
        #1;
        chk("no_load", 32'(strobes), 32'(S_RUN));
        step();
        idle_inputs();

        // branch held during store miss, applied on dhit
        mem_br_taken = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("br_miss_freeze", 32'(strobes), 32'(S_OFF));
            step();
        end
        dhit = 1'b1;
        #1;
        chk("br_dhit", 32'(strobes), 32'(S_BR));
        step();
        idle_inputs();

        // branch beats load-use
        mem_br_taken = 1'b1; exe_memRd = 1'b1; exe_regDst = 5'd5; id_rs = 5'd5;
        #1;
        chk("br_over_luse", 32'(strobes), 32'(S_BR));
        step();
        idle_inputs();

        // icache miss + load-use: luse wins, then plain icache miss
        ihit = 1'b0; exe_memRd = 1'b1; exe_regDst = 5'd9; id_rt = 5'd9;
        #1;
        chk("imiss_luse", 32'(strobes), 32'(S_LUSE));
        step();
        exe_memRd = 1'b0;
        #1;
        chk("imiss_only", 32'(strobes), 32'(S_IMISS));
        step();
        idle_inputs();

        // halt with a non-saturated counter: counter freezes in HALTED
        reset_pulse();
        ihit = 1'b0;
        step();
        step();
        chk("pre_halt_cnt", 32'(stall_cnt), 2);
        ihit = 1'b1; wb_halt = 1'b1;
        #1;
        chk("halt_cycle", 32'(strobes), 32'(S_OFF));
        step();
        chk("halt_set", 32'(halt), 1);
        chk("halt_cnt", 32'(stall_cnt), 3);
        wb_halt = 1'b0; ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halted_strobes", 32'(strobes), 32'(S_OFF));
            chk("halted_flag", 32'(halt), 1);
            chk("halted_cnt", 32'(stall_cnt), 3);
        end
        idle_inputs();

        // saturation, then halt, then reset out of HALTED
        reset_pulse();
        chk("post_halt_rst", 32'(halt), 0);
        ihit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 6) chk("cnt_at_7", 32'(stall_cnt), 7);
        end
        chk("cnt_sat", 32'(stall_cnt), 7);
        ihit = 1'b1; wb_halt = 1'b1;
        step();
        wb_halt = 1'b0;
        chk("sat_halt", 32'(halt), 1);
        chk("sat_cnt_hold", 32'(stall_cnt), 7);
        step();
        chk("sat_halted_strobes", 32'(strobes), 32'(S_OFF));
        RST = 1'b1;
        #1;
        chk("rst_halt_async", 32'(halt), 0);
        chk("rst_cnt_async", 32'(stall_cnt), 0);
        step();
        RST = 1'b0;
        #1;
        chk("rerun_strobes", 32'(strobes), 32'(S_RUN));
        step();
        chk("rerun_cnt", 32'(stall_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
